// File: rtl/crc7_32_dec_arb.sv
// crc7_32_dec_arb: round-robin scheduler sharing one 2-stage CRC-7/32 decoder among N_REQ requesters.
// Latency: a codeword accepted at edge T returns on rsp_* in the cycle after edge T+1 (non-stalled edges only); 1/cycle throughput.
// Backpressure: stall freezes grants, pointer, tags and decoder; the response side has no backpressure.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   stall                freezes arbitration and the decoder pipeline
//   req_valid/req_code   per-requester codeword offer (requester i at req_code[39*i +: 39])
//   req_ready            one-hot accept for the round-robin winner
//   dec_enable/dec_code  drive the shared decoder; a zero codeword is a bubble
//   dec_data/dec_haserr  decoder results, passed straight through to rsp_data/rsp_err
//   rsp_valid/rsp_id     tagged response strobe
//   cnt_clr/err_sel/err_cnt  per-requester error counters, built only with CRC_ARB_ERRCNT_EN
//
// Build option: define CRC_ARB_ERRCNT_EN to build saturating 16-bit error counters per requester.
// Without it err_cnt is tied to 0 and cnt_clr/err_sel are ignored.

module crc7_32_dec_arb #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*39-1:0]  req_code,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 dec_enable,
    output logic [38:0]          dec_code,
    input  logic [31:0]          dec_data,
    input  logic                 dec_haserr,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    input  logic                 cnt_clr,
    input  logic [IDW-1:0]       err_sel,
    output logic [15:0]          err_cnt
);

    // Round-robin pointer and the two tag stages that shadow the decoder pipeline
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           s1_vld_q, s1_vld_d;
    logic [IDW-1:0] s1_id_q, s1_id_d;
    logic           s2_vld_q, s2_vld_d;
    logic [IDW-1:0] s2_id_q, s2_id_d;

    logic           win_found;
    logic [IDW-1:0] win_id;
    logic           xfer;

    // Scan from ptr upward with wrap; first valid requester wins
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
    end

    // Grants are also suppressed while reset is held so req_ready drops immediately
    assign xfer       = win_found & ~stall & reset_n;
    assign dec_enable = ~stall;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[win_id] = 1'b1;
        end
    end

    // Non-transfer cycles feed a zero codeword, which decodes with zero syndrome
    assign dec_code = xfer ? req_code[int'(win_id)*39 +: 39] : 39'h0;

    always_comb begin
        ptr_d    = ptr_q;
        s1_vld_d = s1_vld_q;
        s1_id_d  = s1_id_q;
        s2_vld_d = s2_vld_q;
        s2_id_d  = s2_id_q;
        if (xfer) begin
            ptr_d = (int'(win_id) == N_REQ - 1) ? '0 : win_id + 1'b1;
        end
        if (!stall) begin
            s1_vld_d = xfer;
            s1_id_d  = xfer ? win_id : '0;
            s2_vld_d = s1_vld_q;
            s2_id_d  = s1_id_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q    <= '0;
            s1_vld_q <= 1'b0;
            s1_id_q  <= '0;
            s2_vld_q <= 1'b0;
            s2_id_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            s1_vld_q <= s1_vld_d;
            s1_id_q  <= s1_id_d;
            s2_vld_q <= s2_vld_d;
            s2_id_q  <= s2_id_d;
        end
    end

    // A stalled cycle hides the held response; it reappears once stall drops
    assign rsp_valid = s2_vld_q & ~stall;
    assign rsp_id    = s2_id_q;
    assign rsp_data  = dec_data;
    assign rsp_err   = dec_haserr;

`ifdef CRC_ARB_ERRCNT_EN
    logic [15:0] cnt_q [N_REQ];
    logic [15:0] cnt_d [N_REQ];

    // Clear beats a same-cycle increment; counts saturate at all-ones
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr) begin
                cnt_d[i] = 16'h0;
            end else if (rsp_valid && rsp_err && (int'(rsp_id) == i) && (cnt_q[i] != 16'hFFFF)) begin
                cnt_d[i] = cnt_q[i] + 16'h1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= 16'h0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        err_cnt = 16'h0;
        for (int i = 0; i < N_REQ; i++) begin
            if (int'(err_sel) == i) begin
                err_cnt = cnt_q[i];
            end
        end
    end
`else
    assign err_cnt = 16'h0;
    logic unused_ok;
    assign unused_ok = ^{cnt_clr, err_sel};
`endif

endmodule

// File: tb/tb_crc7_32_dec_arb.sv
module tb_crc7_32_dec_arb;

    localparam int N_REQ = 4;
    localparam int IDW   = 2;

    logic                 clk;
    logic                 reset_n;
    logic                 stall;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ*39-1:0]  req_code;
    logic [N_REQ-1:0]     req_ready;
    logic                 dec_enable;
    logic [38:0]          dec_code;
    logic [31:0]          dec_data;
    logic                 dec_haserr;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_data;
    logic                 rsp_err;
    logic                 cnt_clr;
    logic [IDW-1:0]       err_sel;
    logic [15:0]          err_cnt;

    int checks = 0;
    int errors = 0;

    crc7_32_dec_arb #(.N_REQ(N_REQ), .IDW(IDW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .stall      (stall),
        .req_valid  (req_valid),
        .req_code   (req_code),
        .req_ready  (req_ready),
        .dec_enable (dec_enable),
        .dec_code   (dec_code),
        .dec_data   (dec_data),
        .dec_haserr (dec_haserr),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .cnt_clr    (cnt_clr),
        .err_sel    (err_sel),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CRC-7 (x^7+x^3+1) over 32 data bits, MSB first
    function automatic logic [6:0] crc7(input logic [31:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'h0;
        for (int i = 31; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [38:0] mk(input logic [31:0] d);
        return {d, crc7(d)};
    endfunction

    // Stand-in for the shared decoder: 2-stage pipeline advancing on dec_enable
    logic [38:0] p1 = '0;
    logic [38:0] p2 = '0;
    always @(posedge clk) begin
        if (dec_enable) begin
            p1 <= dec_code;
            p2 <= p1;
        end
    end
    assign dec_data   = p2[38:7];
    assign dec_haserr = (p2[6:0] != crc7(p2[38:7]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_code  = '0;
        stall     = 1'b0;
        cnt_clr   = 1'b0;
        err_sel   = '0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_code  = '0;
        stall     = 1'b0;
        cnt_clr   = 1'b0;
        err_sel   = '0;
        step();
        #2;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
        checks++; if (dec_code !== 39'h0) begin errors++; $display("FAIL reset_dec_code got %h exp 0", dec_code); end
        checks++; if (err_cnt !== 16'h0) begin errors++; $display("FAIL reset_err_cnt got %h exp 0", err_cnt); end
        checks++; if (dec_enable !== 1'b1) begin errors++; $display("FAIL reset_dec_enable got %b exp 1", dec_enable); end
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        logic [38:0] cw;
        do_reset();
        cw = mk(32'hDEADBEEF);
        req_valid = 4'b0100;
        req_code[2*39 +: 39] = cw;
        #2;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", req_ready); end
        checks++; if (dec_code !== cw) begin errors++; $display("FAIL single_dec_code got %h exp %h", dec_code, cw); end
        step();
        req_valid = '0;
        #2;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp got %b exp 0", rsp_valid); end
        checks++; if (dec_code !== 39'h0) begin errors++; $display("FAIL single_bubble got %h exp 0", dec_code); end
        step();
        #2;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %b exp 1", rsp_valid); end
        checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp_id got %0d exp 2", rsp_id); end
        checks++; if (rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rsp_data got %h exp deadbeef", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL single_rsp_err got %b exp 0", rsp_err); end
        step();
        #2;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_one_pulse got %b exp 0", rsp_valid); end
    endtask

    task automatic test_fairness();
        logic [31:0] dat [N_REQ];
        do_reset();
        for (int i = 0; i < N_REQ; i++) begin
            dat[i] = 32'hA0000000 + 32'(i) * 32'h01010101;
            req_code[i*39 +: 39] = mk(dat[i]);
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            if (c == 8) req_valid = '0;
            #2;
            if (c < 8) begin
                checks++;
                if (req_ready !== (4'b0001 << (c % 4))) begin
                    errors++; $display("FAIL fair_grant c=%0d got %b exp %b", c, req_ready, 4'b0001 << (c % 4));
                end
            end
            if (c >= 2) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 2) % 4) || rsp_data !== dat[(c - 2) % 4]) begin
                    errors++; $display("FAIL fair_rsp c=%0d got v=%b id=%0d d=%h exp v=1 id=%0d d=%h",
                                       c, rsp_valid, rsp_id, rsp_data, (c - 2) % 4, dat[(c - 2) % 4]);
                end
            end
            step();
        end
        #2;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL fair_tail got %b exp 0", rsp_valid); end
    endtask

    task automatic test_error();
        do_reset();
        err_sel   = 2'd1;
        req_valid = 4'b0010;
        req_code[1*39 +: 39] = mk(32'h12345678) ^ 39'h1;
        step();
        req_valid = '0;
        step();
        #2;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin errors++; $display("FAIL err_rsp got v=%b id=%0d exp v=1 id=1", rsp_valid, rsp_id); end
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL err_flag got %b exp 1", rsp_err); end
        checks++; if (rsp_data !== 32'h12345678) begin errors++; $display("FAIL err_data got %h exp 12345678", rsp_data); end
        step();
        #2;
`ifdef CRC_ARB_ERRCNT_EN
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL err_cnt_one got %0d exp 1", err_cnt); end
        err_sel = 2'd0;
        #1;
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL err_cnt_other got %0d exp 0", err_cnt); end
`else
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL err_cnt_off got %0d exp 0", err_cnt); end
`endif
    endtask

    task automatic test_stall();
        do_reset();
        req_valid = 4'b0001;
        req_code[0*39 +: 39] = mk(32'hCAFEF00D);
        req_code[1*39 +: 39] = mk(32'h0BADBEEF);
        #2;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL stall_grant0 got %b exp 0001", req_ready); end
        step();
        stall     = 1'b1;
        req_valid = 4'b1111;
        for (int c = 1; c <= 3; c++) begin
            #2;
            checks++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || dec_enable !== 1'b0) begin
                errors++; $display("FAIL stall_hold c=%0d got rdy=%b v=%b en=%b exp rdy=0000 v=0 en=0", c, req_ready, rsp_valid, dec_enable);
            end
            step();
        end
        stall     = 1'b0;
        req_valid = '0;
        #2;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_c4 got %b exp 0", rsp_valid); end
        step();
        req_valid = 4'b1111;
        #2;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'hCAFEF00D) begin
            errors++; $display("FAIL stall_rsp got v=%b id=%0d d=%h exp v=1 id=0 d=cafef00d", rsp_valid, rsp_id, rsp_data);
        end
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL stall_ptr got %b exp 0010", req_ready); end
        step();
        req_valid = '0;
        #2;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_once got %b exp 0", rsp_valid); end
        step();
        #2;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'h0BADBEEF) begin
            errors++; $display("FAIL stall_next got v=%b id=%0d d=%h exp v=1 id=1 d=0badbeef", rsp_valid, rsp_id, rsp_data);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < N_REQ; i++) req_code[i*39 +: 39] = mk(32'h55000000 + 32'(i));
        req_valid = 4'b1111;
        step();
        step();
        #2;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL arst_pre got %b exp 1", rsp_valid); end
        reset_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL arst_rsp got %b exp 0", rsp_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL arst_ready got %b exp 0000", req_ready); end
        req_valid = '0;
        step();
        step();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #2;
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL arst_stale c=%0d got %b exp 0", c, rsp_valid); end
            step();
        end
        req_valid = 4'b1111;
        #2;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL arst_first got %b exp 0001", req_ready); end
        step();
        req_valid = '0;
    endtask

`ifdef CRC_ARB_ERRCNT_EN
    task automatic test_counter_sat();
        do_reset();
        err_sel   = 2'd0;
        req_valid = 4'b0001;
        req_code[0*39 +: 39] = mk(32'h0F0F0F0F) ^ 39'h1;
        for (int c = 0; c < 65537; c++) step();
        req_valid = '0;
        step();
        step();
        step();
        #2;
        checks++; if (err_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat got %h exp ffff", err_cnt); end
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        step();
        cnt_clr = 1'b1;
        #2;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL cnt_clr_rsp got v=%b e=%b exp 1 1", rsp_valid, rsp_err); end
        step();
        cnt_clr = 1'b0;
        #2;
        checks++; if (err_cnt !== 16'h0) begin errors++; $display("FAIL cnt_clr got %h exp 0", err_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_error();
        test_stall();
        test_async_reset();
`ifdef CRC_ARB_ERRCNT_EN
        test_counter_sat();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc7_32_dec_arb.md
Name: crc7_32_dec_arb

Overview:
- Round-robin arbiter/scheduler that shares one CRC-7/32 decoder instance (39-bit codeword in; 32-bit data and error flag out) between N_REQ requesters.
- Accepts codewords over a valid/ready handshake and drives the decoder's enable and code inputs.
- Tracks requester IDs through the decoder's fixed 2-stage pipeline and returns tagged results on a single response bus.
- Sits between the link-layer receive queues and the shared decoder.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- IDW, 2, requester ID width, equal to clog2(N_REQ)

Ports:
- clk  input  1  clock
- reset_n  input  1  reset
- stall  input  1  freezes arbitration and the decoder pipeline
- req_valid  input  N_REQ  per-requester codeword valid
- req_code  input  N_REQ*39  packed codewords; requester i occupies bits [39*i +: 39]
- req_ready  output  N_REQ  one-hot grant/accept
- dec_enable  output  1  decoder enable
- dec_code  output  39  codeword to decoder
- dec_data  input  32  decoder data output
- dec_haserr  input  1  decoder nonzero-syndrome flag
- rsp_valid  output  1  response strobe
- rsp_id  output  IDW  requester that owns the response
- rsp_data  output  32  decoded data
- rsp_err  output  1  CRC error flag
- cnt_clr  input  1  clear all error counters (optional feature)
- err_sel  input  IDW  counter readback select (optional feature)
- err_cnt  output  16  selected requester's error count (optional feature)

Behaviour:
- Clock and reset: clk is the clock. reset_n is an asynchronous, active-low reset.
- Reset values: round-robin pointer = 0; both tag stages invalid with id = 0; error counters = 0. Resulting outputs: rsp_valid = 0, rsp_id = 0, req_ready = 0, dec_code = 0, err_cnt = 0.
- dec_enable: equals ~stall (combinational). The decoder pipeline advances only when stall is low.
- Arbitration (combinational):
  - Winner = first requester with req_valid high, scanning from ptr upward and wrapping at N_REQ-1 to 0.
  - req_ready[winner] = ~stall. All other req_ready bits are 0.
  - No valid requester, or stall high: req_ready = 0.
- Handshake: a transfer occurs on a rising edge where req_valid[i] and req_ready[i] are both high. req_valid must not depend on req_ready.
- dec_code: equals req_code of the winner when a transfer occurs, otherwise 0. A bubble is a zero codeword (syndrome 0) and carries an invalid tag.
- Pointer: on a transfer, ptr <= winner+1, wrapping N_REQ-1 to 0. With no transfer, ptr holds.
- Tag pipeline (advances only when stall is low):
  - stage1 <= {transfer, winner id}
  - stage2 <= stage1
- Latency: handshake accepted at edge T → response visible in the cycle after edge T+1, counting only non-stalled edges. Back-to-back throughput is 1 codeword per cycle.
- Response outputs:
  - rsp_valid = stage2.valid & ~stall; rsp_id = stage2.id.
  - rsp_data and rsp_err pass through dec_data and dec_haserr.
  - Each response is presented in exactly one non-stalled cycle. No backpressure is applied on the response side.
- Stall mid-flight:
  - Grants, pointer, tags and decoder hold. rsp_valid = 0.
  - The held response reappears on the first cycle with stall low and retires at that edge.
- Reset mid-operation: all in-flight tags are discarded and no responses are emitted for them. Requesters must re-present their codewords.

Optional Feature:
- Macro: CRC_ARB_ERRCNT_EN
- Defined:
  - One 16-bit counter per requester. It increments on rsp_valid & rsp_err for rsp_id and saturates at 0xFFFF.
  - cnt_clr clears all counters at the next edge and wins over a simultaneous increment.
  - err_cnt = counter[err_sel] (combinational). An err_sel value >= N_REQ returns 0.
- Undefined: no counters are built; err_cnt = 0 and cnt_clr and err_sel are ignored.

Test Plan:
- Single requester: req_valid[2]=1 with one valid codeword (zero syndrome) for one handshake → req_ready=0100 that cycle; 2 cycles later rsp_valid=1, rsp_id=2, rsp_data = the codeword's bits [7:38], rsp_err=0; exactly one pulse.
- Fairness: all 4 requesters hold req_valid=1 for 8 cycles from reset → grant order 0,1,2,3,0,1,2,3; responses carry the same ids, each 2 cycles behind its grant.
- Error path: requester 1 sends a valid codeword with bit 0 flipped → rsp_err=1, rsp_id=1; with CRC_ARB_ERRCNT_EN and err_sel=1, err_cnt=1.
- Stall: grant at cycle 0, stall=1 during cycles 1-3 → req_ready=0 and rsp_valid=0 during the stall; response appears in cycle 5 exactly once, and the pointer is unchanged across the stall.
- Counter saturation and clear: force 65537 errors on id 0 → err_cnt=0xFFFF; assert cnt_clr in the same cycle as an error response → err_cnt=0 next cycle.
- Async reset: assert reset_n=0 mid-cycle with two responses in flight → rsp_valid and req_ready drop to 0 immediately; after release, no stale responses appear and the first grant goes to requester 0.
